// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, key codes and the row/column to code map for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    localparam logic [3:0] KEY_NONE      = 4'hF;
    localparam logic [3:0] KEY_BACKSPACE = 4'hC;
    localparam key_pos_t   KEY_ENTER_POS = '{row: 2'd3, col: 2'd2};

    // '#' maps to KEY_NONE so it can never leak onto the key code bus
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        if (col == 2'd3)
            return row == 2'd0 ? 4'hA : row == 2'd1 ? 4'hB : row == 2'd2 ? KEY_BACKSPACE : 4'hD;
        if (row != 2'd3)
            return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        return col == 2'd0 ? 4'hE : col == 2'd1 ? 4'h0 : KEY_NONE;
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchronizer for asynchronous inputs, reset to all-ones (idle pulled-up level).
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scans a 4x4 keypad, debounces press and release,
// and presents one key code per press on key_data ('#' only pulses key_enter).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_enter
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d, row_q, row_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic [3:0]    key_data_q, key_data_d;
    logic          key_valid_q, key_valid_d, key_enter_q, key_enter_d;

    logic [3:0]    row_s;
    logic          sample, any_low, is_enter;
    logic [1:0]    low_idx;
    logic [DW-1:0] dbc_inc;

    key_sync #(.W(4)) u_row_sync (.clk(clk), .rstn(rstn), .d(row_in), .q(row_s));

    // sampling only at the end of a slot gives the column drive a full slot to settle
    assign sample   = slot_q == SW'(SCAN_DIV - 1);
    assign any_low  = ~&row_s;
    assign low_idx  = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
    assign dbc_inc  = dbc_q + 1'b1;
    assign is_enter = {row_q, col_q} == KEY_ENTER_POS;

    always_comb begin
        slot_d      = sample ? '0 : slot_q + 1'b1;
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dbc_d       = dbc_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        key_enter_d = 1'b0;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_d   = low_idx;
                        dbc_d   = DW'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && low_idx == row_q) begin
                        dbc_d = dbc_inc;
                        if (dbc_inc == DW'(DEBOUNCE_CNT)) begin
                            state_d     = PRESSED;
                            dbc_d       = '0;
                            key_data_d  = is_enter ? KEY_NONE : key_code(row_q, col_q);
                            key_valid_d = !is_enter;
                            key_enter_d = is_enter;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                PRESSED: begin
                    // dbc now counts consecutive release samples of the owning row only
                    dbc_d = row_s[row_q] ? dbc_inc : '0;
                    if (row_s[row_q] && dbc_inc == DW'(DEBOUNCE_CNT)) begin
                        state_d    = SCAN;
                        col_d      = col_q + 2'd1;
                        dbc_d      = '0;
                        key_data_d = KEY_NONE;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            slot_q      <= '0;
            dbc_q       <= '0;
            key_data_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_enter_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            slot_q      <= slot_d;
            dbc_q       <= dbc_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            key_enter_q <= key_enter_d;
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_enter = key_enter_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad model drives rows from held keys; a scoreboard of expected
// key events is consumed by an independent monitor watching key_data/key_valid/key_enter.
module tb_keypad_matrix_scanner;

    localparam int EV_VALID = 0;
    localparam int EV_ENTER = 1;
    localparam int EV_REL   = 2;

    typedef struct {
        int         kind;
        logic [3:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] row_in, col_out, key_data;
    logic       key_valid, key_enter;
    logic [3:0] keys [4];

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rstn(rstn), .row_in(row_in), .col_out(col_out),
        .key_data(key_data), .key_valid(key_valid), .key_enter(key_enter)
    );

    always #5 clk = ~clk;

    // a row reads low when any held key in it sits on the column being driven low
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r] & ~col_out);
    end

    task automatic push(input int kind, input logic [3:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [3:0] code);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d code %h, required no event", kind, code);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.code !== code) begin
                errors++;
                $display("FAIL event: got kind %0d code %h, required kind %0d code %h",
                         kind, code, e.kind, e.code);
            end
        end
    endtask

    initial begin : monitor
        logic [3:0] prev;
        wait (rstn === 1'b1);
        prev = key_data;
        forever begin
            @(negedge clk);
            checks++;
            if ($countones(~col_out) != 1) begin
                errors++;
                $display("FAIL col_onehot: col_out %b, required exactly one low bit", col_out);
            end
            if (key_valid && key_enter) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap: key_valid %b key_enter %b, required not both", key_valid, key_enter);
            end
            if (key_valid)               check_ev(EV_VALID, key_data);
            else if (key_enter)          check_ev(EV_ENTER, key_data);
            else if (key_data !== prev)  check_ev(EV_REL, key_data);
            prev = key_data;
        end
    end

    task automatic drain(input string name, input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, sb.size(), max);
            sb.delete();
        end
    endtask

    task automatic wait_col(input string name, input logic [3:0] want, input int max);
        int n = 0;
        while (col_out !== want && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (col_out !== want) begin
            errors++;
            $display("FAIL %s: col_out %b, required %b within %0d cycles", name, col_out, want, max);
        end
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        repeat (3) @(negedge clk);
        check_val("reset_col_out", col_out, 4'b1110);
        check_val("reset_key_data", key_data, 4'hF);
        check_val("reset_key_valid", {3'b000, key_valid}, 4'h0);
        check_val("reset_key_enter", {3'b000, key_enter}, 4'h0);
        rstn = 1'b1;
        wait_col("rotate_c1", 4'b1101, 20);
        wait_col("rotate_c2", 4'b1011, 20);

        // clean '5'
        push(EV_VALID, 4'h5);
        keys[1][1] = 1'b1;
        drain("press_5", 200);
        hold(100);
        push(EV_REL, 4'hF);
        keys[1][1] = 1'b0;
        drain("release_5", 200);
        wait_col("resume_c3", 4'b0111, 40);
        wait_col("resume_c0", 4'b1110, 40);

        // bouncing '9': alternating samples never reach three consecutive lows
        push(EV_VALID, 4'h9);
        for (int i = 0; i < 8; i++) begin
            keys[2][2] = ~keys[2][2];
            hold(4);
        end
        keys[2][2] = 1'b1;
        drain("press_9", 300);
        push(EV_REL, 4'hF);
        keys[2][2] = 1'b0;
        drain("release_9", 200);

        // 'C' twice
        for (int i = 0; i < 2; i++) begin
            push(EV_VALID, 4'hC);
            keys[2][3] = 1'b1;
            drain("press_C", 200);
            hold(10);
            push(EV_REL, 4'hF);
            keys[2][3] = 1'b0;
            drain("release_C", 200);
        end

        // '#'
        push(EV_ENTER, 4'hF);
        keys[3][2] = 1'b1;
        drain("press_enter", 200);
        hold(20);
        keys[3][2] = 1'b0;
        hold(60);

        // '2' owns the bus over '8'; '8' is taken after '2' releases
        push(EV_VALID, 4'h2);
        keys[0][1] = 1'b1;
        drain("press_2", 200);
        keys[2][1] = 1'b1;
        hold(50);
        push(EV_REL, 4'hF);
        push(EV_VALID, 4'h8);
        keys[0][1] = 1'b0;
        drain("release_2_then_8", 300);
        push(EV_REL, 4'hF);
        keys[2][1] = 1'b0;
        drain("release_8", 200);

        // reset while '7' is pressed
        push(EV_VALID, 4'h7);
        keys[2][0] = 1'b1;
        drain("press_7", 200);
        hold(5);
        push(EV_REL, 4'hF);
        push(EV_VALID, 4'h7);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst7_key_data", key_data, 4'hF);
        check_val("rst7_col_out", col_out, 4'b1110);
        check_val("rst7_strobes", {2'b00, key_valid, key_enter}, 4'h0);
        @(negedge clk);
        rstn = 1'b1;
        drain("reaccept_7", 200);
        push(EV_REL, 4'hF);
        keys[2][0] = 1'b0;
        drain("release_7", 200);
        hold(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives a 4x4 membrane keypad by column scanning, debounces presses and releases, and encodes the pressed key onto a 4-bit key code bus.
- Is the producer end of the key-code interface feeding the keyboard digit cache.
- Bus protocol: 4'hF = no key; every change away from 4'hF is one key event.

Parameters:
- SCAN_DIV, 100000: clock cycles per column slot (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_CNT, 20: consecutive identical row samples required to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock, 100 MHz
- rstn  input  1  reset, synchronous, active-low
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  output  4  column drive, active-low, exactly one bit low at any time
- key_data  output  4  key code; 4'hF when no key is held
- key_valid  output  1  one-cycle strobe on the cycle key_data takes a new code
- key_enter  output  1  one-cycle strobe when '#' press is accepted

Behaviour:
- Layout [row][col]: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
- Codes: digits -> 4'h0..4'h9; A/B/C/D -> 4'hA..4'hD; '*' -> 4'hE.
- 4'hC is the backspace code consumed downstream.
- '#' never appears on key_data: it pulses key_enter and key_data stays 4'hF.
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Slot counter runs 0..SCAN_DIV-1. A row sample is taken only when the counter = SCAN_DIV-1, which leaves settle time after a column change.
- Reset (any state, any cycle): state=SCAN, col index 0, col_out=4'b1110, slot counter 0, debounce counter 0, key_data=4'hF, key_valid=0, key_enter=0.
- Reset during PRESSED drops key_data to 4'hF with no strobe.
- State SCAN:
  - At the sample point, if all rows read high, advance the column (0->1->2->3->0) and update col_out in the same cycle.
  - If any row reads low, latch the lowest-index low row plus the current column, clear the debounce counter to 1, go to DEBOUNCE. The column is not advanced.
- State DEBOUNCE (column held):
  - At each sample point, if the latched row is low and all lower-index rows are high, increment the counter.
  - Otherwise return to SCAN and advance the column.
  - When the counter reaches DEBOUNCE_CNT, go to PRESSED. On the next cycle: key_data = code and key_valid=1 for one cycle, or key_enter=1 for one cycle if the key is '#'.
- State PRESSED (column held, key_data held):
  - At each sample point, if the latched row is high, increment the release counter; if low, clear it.
  - When the release counter reaches DEBOUNCE_CNT, key_data <= 4'hF on the next cycle, go to SCAN and advance the column.
- Multiple keys:
  - The first accepted key owns the bus until its release.
  - Other keys, including keys in the same column, are ignored while PRESSED.
  - Within one sample, the lowest-index row wins.
- Same key pressed twice always produces 4'hF in between, so each press is a distinct transition downstream.
- No auto-repeat. key_valid and key_enter are never asserted together.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED}
  - constants KEY_NONE=4'hF, KEY_BACKSPACE=4'hC, KEY_ENTER_POS (row 3, col 2)
  - function key_code(row, col) returning the 4-bit code
- Sub-module: key_sync, a parameterized-width 2-flop synchronizer reset to all-ones, instanced once for row_in.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Clean press of '5' (row1 low while col1 driven), held 100 cycles, then released -> key_data=4'h5 with one key_valid pulse; key_data returns to 4'hF after 3 consecutive high samples; col_out resumes rotating.
- Bounce on '9' (row2 toggles at the first 2 col2 samples, then stable low) -> no event until 3 consecutive low samples; exactly one key_valid; key_data=4'h9.
- Press 'C', release, press 'C' again -> key_data sequence F, C, F, C; two key_valid pulses.
- Press '#' -> one key_enter pulse, key_valid stays 0, key_data stays 4'hF throughout.
- Hold '2' (r0c1) and then '8' (r2c1) together -> key_data=4'h2 only. After '2' releases with '8' still held -> key_data goes to F, then to 4'h8 after debounce.
- Assert rstn=0 for one cycle while '7' is PRESSED -> next cycle key_data=4'hF, col_out=4'b1110, no strobe. With '7' still held, it is re-accepted as 4'h7 after debounce.
